// File: rtl/io_register_block_if.sv
// IO-register window bus between the memory mapper and its responder.
// Word-aligned address, byte-enabled writes, registered read data.
interface io_register_block_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] io_reg_addr;
  logic [31:0]       io_reg_wr_data;
  logic [3:0]        io_reg_wr_en;
  logic [31:0]       io_reg_rd_data;

  modport master (
    output io_reg_addr,
    output io_reg_wr_data,
    output io_reg_wr_en,
    input  io_reg_rd_data
  );

  modport slave (
    input  io_reg_addr,
    input  io_reg_wr_data,
    input  io_reg_wr_en,
    output io_reg_rd_data
  );
endinterface

// File: rtl/io_register_block.sv
// IO-register responder: ID, scratch, cycle snapshot, down-timer,
// vsync status, IRQ and LED registers with 1-cycle read latency.
module io_register_block #(
  parameter int          IO_REGISTERS_BYTES = 4096,
  parameter logic [31:0] ID_VALUE           = 32'h4750_5530,
  parameter int          LED_WIDTH          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  io_register_block_if.slave   bus,
  input  logic                 vsync,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq
);

  localparam int ADDR_W = $clog2(IO_REGISTERS_BYTES);
  localparam int WI_W   = ADDR_W - 2;

  typedef logic [WI_W-1:0] widx_t;

  localparam widx_t R_ID      = widx_t'(0);
  localparam widx_t R_SCRATCH = widx_t'(1);
  localparam widx_t R_SNAP_LO = widx_t'(2);
  localparam widx_t R_SNAP_HI = widx_t'(3);
  localparam widx_t R_TCTRL   = widx_t'(4);
  localparam widx_t R_TLOAD   = widx_t'(5);
  localparam widx_t R_TCOUNT  = widx_t'(6);
  localparam widx_t R_STATUS  = widx_t'(7);
  localparam widx_t R_IRQ_EN  = widx_t'(8);
  localparam widx_t R_LEDS    = widx_t'(9);

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8]
                          : old_v[8*b +: 8];
    end
    return r;
  endfunction

  widx_t       widx;
  logic [1:0]  unused_addr_lsb;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        wr_any;
  logic        wr_b0;

  assign widx            = bus.io_reg_addr[ADDR_W-1:2];
  assign unused_addr_lsb = bus.io_reg_addr[1:0];
  assign wdata           = bus.io_reg_wr_data;
  assign be              = bus.io_reg_wr_en;
  assign wr_any          = |be;
  assign wr_b0           = be[0];

  logic sel_id, sel_scratch, sel_snap_lo, sel_snap_hi;
  logic sel_tctrl, sel_tload, sel_tcount, sel_status;
  logic sel_irq_en, sel_leds;

  assign sel_id      = (widx == R_ID);
  assign sel_scratch = (widx == R_SCRATCH);
  assign sel_snap_lo = (widx == R_SNAP_LO);
  assign sel_snap_hi = (widx == R_SNAP_HI);
  assign sel_tctrl   = (widx == R_TCTRL);
  assign sel_tload   = (widx == R_TLOAD);
  assign sel_tcount  = (widx == R_TCOUNT);
  assign sel_status  = (widx == R_STATUS);
  assign sel_irq_en  = (widx == R_IRQ_EN);
  assign sel_leds    = (widx == R_LEDS);

  logic [63:0]          cycle_q;
  logic [63:0]          snap_q;
  logic [31:0]          scratch_q;
  logic                 t_en_q;
  logic                 t_ar_q;
  logic [31:0]          tload_q;
  logic [31:0]          tcount_q;
  logic [1:0]           status_q;
  logic [1:0]           irq_en_q;
  logic [LED_WIDTH-1:0] leds_q;
  logic                 vsync_q;
  logic [31:0]          rd_q;

  logic                 t_en_n;
  logic                 t_ar_n;
  logic [31:0]          tload_n;
  logic [31:0]          tcount_n;
  logic                 t_fire;
  logic [1:0]           st_clr;
  logic [1:0]           st_set;
  logic [1:0]           status_n;
  logic [LED_WIDTH-1:0] leds_n;
  logic [31:0]          rd_n;

  // Hardware timer step first; register writes then override it.
  always_comb begin
    t_en_n   = t_en_q;
    t_ar_n   = t_ar_q;
    tload_n  = tload_q;
    tcount_n = tcount_q;
    t_fire   = 1'b0;
    if (t_en_q) begin
      if (tcount_q != '0) begin
        tcount_n = tcount_q - 32'd1;
      end else begin
        t_fire = 1'b1;
        if (t_ar_q) tcount_n = tload_q;
        else        t_en_n   = 1'b0;
      end
    end
    if (sel_tctrl && wr_b0) begin
      t_en_n = wdata[0];
      t_ar_n = wdata[1];
    end
    if (sel_tload && wr_any) begin
      tload_n  = merge(tload_q, wdata, be);
      tcount_n = tload_n;
    end
  end

  // Hardware set beats a same-cycle W1C clear.
  always_comb begin
    st_clr   = (sel_status && wr_b0) ? wdata[1:0] : 2'b00;
    st_set   = {vsync & ~vsync_q, t_fire};
    status_n = (status_q & ~st_clr) | st_set;
  end

  always_comb begin
    leds_n = leds_q;
    if (sel_leds) begin
      for (int i = 0; i < LED_WIDTH; i++) begin
        if (be[i/8]) leds_n[i] = wdata[i];
      end
    end
  end

  always_comb begin
    rd_n = '0;
    unique case (1'b1)
      sel_id:      rd_n = ID_VALUE;
      sel_scratch: rd_n = scratch_q;
      sel_snap_lo: rd_n = snap_q[31:0];
      sel_snap_hi: rd_n = snap_q[63:32];
      sel_tctrl:   rd_n = {30'd0, t_ar_q, t_en_q};
      sel_tload:   rd_n = tload_q;
      sel_tcount:  rd_n = tcount_q;
      sel_status:  rd_n = {30'd0, status_q};
      sel_irq_en:  rd_n = {30'd0, irq_en_q};
      sel_leds:    rd_n[LED_WIDTH-1:0] = leds_q;
      default:     rd_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      snap_q    <= '0;
      scratch_q <= '0;
      t_en_q    <= 1'b0;
      t_ar_q    <= 1'b0;
      tload_q   <= '0;
      tcount_q  <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      leds_q    <= '0;
      vsync_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      cycle_q  <= cycle_q + 64'd1;
      if (sel_snap_lo && wr_any) snap_q <= cycle_q;
      if (sel_scratch) begin
        scratch_q <= merge(scratch_q, wdata, be);
      end
      t_en_q   <= t_en_n;
      t_ar_q   <= t_ar_n;
      tload_q  <= tload_n;
      tcount_q <= tcount_n;
      status_q <= status_n;
      if (sel_irq_en && wr_b0) irq_en_q <= wdata[1:0];
      leds_q   <= leds_n;
      vsync_q  <= vsync;
      rd_q     <= rd_n;
    end
  end

  assign bus.io_reg_rd_data = rd_q;
  assign leds               = leds_q;
  assign irq                = |(status_q & irq_en_q);

endmodule

// File: tb/tb_io_register_block.sv
// Bench for io_register_block: directed literal checks plus a
// randomized run against a register-level reference model.
module tb_io_register_block;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic [7:0] leds;
  logic       irq;

  io_register_block_if #(.ADDR_W(12)) bus();

  io_register_block #(
    .IO_REGISTERS_BYTES(4096),
    .ID_VALUE(32'h4750_5530),
    .LED_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .vsync(vsync),
    .leds(leds),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit [63:0] m_cnt;
  bit [63:0] m_snap;
  bit [31:0] m_scratch;
  bit        m_en;
  bit        m_ar;
  bit [31:0] m_tload;
  bit [31:0] m_tcount;
  bit [1:0]  m_status;
  bit [1:0]  m_irqen;
  bit [7:0]  m_leds;
  bit        m_vprev;

  logic [31:0] exp_rd;
  logic [7:0]  exp_leds;
  logic        exp_irq;
  bit          armed = 0;
  bit          vs_lvl = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, req, $time);
    end
  endtask

  function automatic bit [31:0] bmerge(bit [31:0] o,
                                       bit [31:0] d,
                                       bit [3:0] be);
    bit [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction

  function automatic bit [31:0] mread(bit [11:0] off);
    case (off)
      12'h000: return 32'h4750_5530;
      12'h004: return m_scratch;
      12'h008: return m_snap[31:0];
      12'h00C: return m_snap[63:32];
      12'h010: return {30'd0, m_ar, m_en};
      12'h014: return m_tload;
      12'h018: return m_tcount;
      12'h01C: return {30'd0, m_status};
      12'h020: return {30'd0, m_irqen};
      12'h024: return {24'd0, m_leds};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit [11:0] a, input bit [31:0] d,
                            input bit [3:0] be, input bit vs,
                            input bit r);
    bit [11:0] off;
    bit        fire;
    bit        en_n;
    bit [31:0] tc_n;
    bit [1:0]  clr;
    if (r) begin
      m_cnt = 0; m_snap = 0; m_scratch = 0;
      m_en = 0; m_ar = 0; m_tload = 0; m_tcount = 0;
      m_status = 0; m_irqen = 0; m_leds = 0;
      exp_rd = 0;
    end else begin
      off = a & 12'hFFC;
      exp_rd = mread(off);
      fire = 0;
      en_n = m_en;
      tc_n = m_tcount;
      if (m_en) begin
        if (m_tcount > 0) tc_n = m_tcount - 1;
        else begin
          fire = 1;
          if (m_ar) tc_n = m_tload;
          else en_n = 0;
        end
      end
      if (off == 12'h010 && be[0]) begin
        en_n = d[0];
        m_ar = d[1];
      end
      if (off == 12'h014 && be != 0) begin
        m_tload = bmerge(m_tload, d, be);
        tc_n = m_tload;
      end
      m_en = en_n;
      m_tcount = tc_n;
      clr = (off == 12'h01C && be[0]) ? d[1:0] : 2'b00;
      m_status = (m_status & ~clr) | {vs & ~m_vprev, fire};
      if (off == 12'h004) m_scratch = bmerge(m_scratch, d, be);
      if (off == 12'h008 && be != 0) m_snap = m_cnt;
      if (off == 12'h020 && be[0]) m_irqen = d[1:0];
      if (off == 12'h024) m_leds = 8'(bmerge({24'd0, m_leds}, d, be));
      m_cnt = m_cnt + 1;
    end
    m_vprev = r ? 1'b0 : vs;
    exp_leds = m_leds;
    exp_irq = |(m_status & m_irqen);
  endtask

  task automatic acc(input bit [11:0] a, input bit [31:0] d,
                     input bit [3:0] be, input bit r = 0);
    @(negedge clk);
    bus.io_reg_addr    = a;
    bus.io_reg_wr_data = d;
    bus.io_reg_wr_en   = be;
    reset              = r;
    vsync              = vs_lvl;
    model_step(a, d, be, vs_lvl, r);
    armed = 1;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    if (armed) begin
      chk("rd_data", bus.io_reg_rd_data, exp_rd);
      chk("leds", {24'd0, leds}, {24'd0, exp_leds});
      chk("irq", {31'd0, irq}, {31'd0, exp_irq});
    end
  end

  localparam bit [31:0] TC_SEQ [8] = '{3, 2, 1, 0, 3, 2, 1, 0};

  initial begin
    bus.io_reg_addr    = '0;
    bus.io_reg_wr_data = '0;
    bus.io_reg_wr_en   = '0;

    acc(12'h000, 0, 0, 1);
    acc(12'h3FC, 0, 0, 1);
    chk("reset_rd", bus.io_reg_rd_data, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    acc(12'h000, 0, 0);
    chk("id", bus.io_reg_rd_data, 32'h4750_5530);
    acc(12'h3FC, 0, 0);
    chk("unmapped", bus.io_reg_rd_data, 32'd0);

    acc(12'h004, 32'hDEADBEEF, 4'hF);
    acc(12'h004, 32'h0000_1200, 4'b0010);
    acc(12'h004, 0, 0);
    chk("scratch", bus.io_reg_rd_data, 32'hDEAD12EF);

    acc(12'h014, 3, 4'hF);
    acc(12'h010, 3, 4'h1);
    for (int i = 0; i < 8; i++) begin
      acc(12'h018, 0, 0);
      chk("tcount_seq", bus.io_reg_rd_data, TC_SEQ[i]);
    end
    acc(12'h020, 1, 4'h1);
    chk("irq_on", {31'd0, irq}, 32'd1);
    acc(12'h010, 0, 4'h1);
    acc(12'h01C, 1, 4'h1);
    chk("irq_off", {31'd0, irq}, 32'd0);
    acc(12'h01C, 0, 0);
    chk("status_clr", bus.io_reg_rd_data, 32'd0);

    acc(12'h014, 2, 4'hF);
    acc(12'h010, 1, 4'h1);
    for (int i = 0; i < 5; i++) acc(12'h3FC, 0, 0);
    acc(12'h010, 0, 0);
    chk("oneshot_tctrl", bus.io_reg_rd_data, 32'd0);
    acc(12'h018, 0, 0);
    chk("oneshot_tcount", bus.io_reg_rd_data, 32'd0);
    acc(12'h01C, 0, 0);
    chk("oneshot_status", bus.io_reg_rd_data, 32'd1);

    acc(12'h01C, 3, 4'h1);
    vs_lvl = 1;
    acc(12'h01C, 2, 4'h1);
    acc(12'h01C, 0, 0);
    chk("vsync_set_wins", bus.io_reg_rd_data, 32'd2);
    vs_lvl = 0;

    acc(12'h000, 0, 0, 1);
    for (int i = 0; i < 100; i++) acc(12'h3FC, 0, 0);
    acc(12'h008, 0, 4'h1);
    acc(12'h008, 0, 0);
    chk("snap_lo", bus.io_reg_rd_data, 32'd100);
    acc(12'h00C, 0, 0);
    chk("snap_hi", bus.io_reg_rd_data, 32'd0);

    acc(12'h024, 32'hA5, 4'h1);
    acc(12'h014, 50, 4'hF);
    acc(12'h010, 3, 4'h1);
    for (int i = 0; i < 5; i++) acc(12'h3FC, 0, 0);
    acc(12'h004, 32'h1234, 4'hF, 1);
    for (int i = 0; i < 10; i++) begin
      acc(12'(4 * i), 0, 0);
      chk("post_reset", bus.io_reg_rd_data,
          (i == 0) ? 32'h4750_5530 : 32'd0);
    end

    for (int n = 0; n < 4000; n++) begin
      int sel;
      bit [11:0] a;
      bit [31:0] d;
      bit [3:0]  be;
      sel = $urandom_range(0, 15);
      if (sel < 10) a = 12'(sel * 4) | 12'($urandom_range(0, 3));
      else          a = 12'($urandom);
      d = $urandom;
      if ((a & 12'hFFC) == 12'h014) d = $urandom_range(0, 9);
      be = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 3) == 0) vs_lvl = ~vs_lvl;
      acc(a, d, be, $urandom_range(0, 299) == 0);
    end

    armed = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
